// File: rtl/fire_pkg.sv
// Shared widths, FSM state encoding and memory word layouts for the fire datapath.
package fire_pkg;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned EPTR_W = 12;
  localparam int unsigned W_W    = 16;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned PTR_W  = 2 * EPTR_W;
  localparam int unsigned EDGE_W = TAG_W + W_W;

  // ptr_rdata = {end, begin}
  localparam int unsigned PTR_BEGIN_LSB = 0;
  localparam int unsigned PTR_END_LSB   = EPTR_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PTR_WAIT = 2'd1,
    ST_EDGE_RD  = 2'd2,
    ST_EDGE_OUT = 2'd3
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] dst;
    logic [W_W-1:0]   weight;
  } edge_t;

  // An end of 0 stands for the top of the address space, so only a non-zero end below begin is malformed.
  function automatic logic ptr_malformed(input logic [EPTR_W-1:0] ptr_begin,
                                         input logic [EPTR_W-1:0] ptr_end);
    return (ptr_end != '0) && (ptr_end < ptr_begin);
  endfunction

endpackage

// File: rtl/fanout_counters.sv
// Spike/event statistics counters and the sticky malformed-pointer flag.
module fanout_counters
  import fire_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_inc,
  input  logic             event_inc,
  input  logic             err_set,
  output logic [CNT_W-1:0] spike_cnt,
  output logic [CNT_W-1:0] event_cnt,
  output logic             ptr_err
);

  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic             ptr_err_q, ptr_err_d;

  always_comb begin
    spike_cnt_d = spike_cnt_q;
    event_cnt_d = event_cnt_q;
    ptr_err_d   = ptr_err_q;
    if (spike_inc) spike_cnt_d = spike_cnt_q + CNT_W'(1);
    if (event_inc) event_cnt_d = event_cnt_q + CNT_W'(1);
    if (err_set)   ptr_err_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt_q <= '0;
      event_cnt_q <= '0;
      ptr_err_q   <= 1'b0;
    end else begin
      spike_cnt_q <= spike_cnt_d;
      event_cnt_q <= event_cnt_d;
      ptr_err_q   <= ptr_err_d;
    end
  end

  assign spike_cnt = spike_cnt_q;
  assign event_cnt = event_cnt_q;
  assign ptr_err   = ptr_err_q;

endmodule

// File: rtl/spike_fanout_dispatcher.sv
// Pops fired-neuron tags and walks their CSR edge lists, emitting one synapse event per edge.
module spike_fanout_dispatcher
  import fire_pkg::*;
(
  input  logic              clk,
  input  logic              asyn_reset_n,
  input  logic              run,
  input  logic              fifo_empty,
  input  logic [TAG_W-1:0]  fifo_out_tag,
  output logic              fifo_deq,
  output logic [TAG_W-1:0]  ptr_addr,
  input  logic [PTR_W-1:0]  ptr_rdata,
  output logic [EPTR_W-1:0] edge_addr,
  input  logic [EDGE_W-1:0] edge_rdata,
  output logic              syn_valid,
  input  logic              syn_ready,
  output logic [TAG_W-1:0]  syn_dst,
  output logic [W_W-1:0]    syn_weight,
  output logic              busy,
  output logic              ptr_err,
  output logic [CNT_W-1:0]  spike_cnt,
  output logic [CNT_W-1:0]  event_cnt
);

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic [EPTR_W-1:0] cur_q, cur_d;
  logic [EPTR_W-1:0] end_q, end_d;
  logic [EPTR_W-1:0] edge_addr_q, edge_addr_d;
  logic              syn_valid_q, syn_valid_d;
  logic [TAG_W-1:0]  syn_dst_q, syn_dst_d;
  logic [W_W-1:0]    syn_weight_q, syn_weight_d;
  logic              busy_q, busy_d;

  logic              pop_c, accept_c, err_c;
  logic [EPTR_W-1:0] ptr_begin_c, ptr_end_c, cur_inc_c;
  edge_t             edge_c;

  assign ptr_begin_c = ptr_rdata[PTR_BEGIN_LSB +: EPTR_W];
  assign ptr_end_c   = ptr_rdata[PTR_END_LSB +: EPTR_W];
  assign cur_inc_c   = cur_q + EPTR_W'(1);
  assign edge_c      = edge_t'(edge_rdata);

  // Next-state and datapath; addresses are decided here so the memories see them one edge early.
  always_comb begin
    state_d      = state_q;
    armed_d      = 1'b1;
    cur_tag_d    = cur_tag_q;
    cur_d        = cur_q;
    end_d        = end_q;
    edge_addr_d  = edge_addr_q;
    syn_valid_d  = syn_valid_q;
    syn_dst_d    = syn_dst_q;
    syn_weight_d = syn_weight_q;
    pop_c        = 1'b0;
    accept_c     = 1'b0;
    err_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && run && !fifo_empty) begin
          pop_c     = 1'b1;
          cur_tag_d = fifo_out_tag;
          state_d   = ST_PTR_WAIT;
        end
      end
      ST_PTR_WAIT: begin
        if (ptr_end_c == ptr_begin_c) begin
          state_d = ST_IDLE;
        end else if (ptr_malformed(ptr_begin_c, ptr_end_c)) begin
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cur_d       = ptr_begin_c;
          end_d       = ptr_end_c;
          edge_addr_d = ptr_begin_c;
          state_d     = ST_EDGE_RD;
        end
      end
      ST_EDGE_RD: begin
        syn_valid_d  = 1'b1;
        syn_dst_d    = edge_c.dst;
        syn_weight_d = edge_c.weight;
        state_d      = ST_EDGE_OUT;
      end
      ST_EDGE_OUT: begin
        if (syn_ready) begin
          accept_c    = 1'b1;
          syn_valid_d = 1'b0;
          if (cur_inc_c == end_q) begin
            state_d = ST_IDLE;
          end else begin
            cur_d       = cur_inc_c;
            edge_addr_d = cur_inc_c;
            state_d     = ST_EDGE_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      cur_tag_q    <= '0;
      cur_q        <= '0;
      end_q        <= '0;
      edge_addr_q  <= '0;
      syn_valid_q  <= 1'b0;
      syn_dst_q    <= '0;
      syn_weight_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      cur_tag_q    <= cur_tag_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      edge_addr_q  <= edge_addr_d;
      syn_valid_q  <= syn_valid_d;
      syn_dst_q    <= syn_dst_d;
      syn_weight_q <= syn_weight_d;
      busy_q       <= busy_d;
    end
  end

  fanout_counters u_counters (
    .clk       (clk),
    .rst_n     (asyn_reset_n),
    .spike_inc (pop_c),
    .event_inc (accept_c),
    .err_set   (err_c),
    .spike_cnt (spike_cnt),
    .event_cnt (event_cnt),
    .ptr_err   (ptr_err)
  );

  assign fifo_deq   = pop_c;
  assign ptr_addr   = cur_tag_d;
  assign edge_addr  = edge_addr_d;
  assign syn_valid  = syn_valid_q;
  assign syn_dst    = syn_dst_q;
  assign syn_weight = syn_weight_q;
  assign busy       = busy_q;

endmodule

// File: doc/spike_fanout_dispatcher.md
Name: spike_fanout_dispatcher

Overview:
- Consumer stage directly downstream of fire_fifo. It pops fired-neuron tags and walks each neuron's outgoing-edge list.
- Edge lists are stored in compressed-sparse-row form: a pointer table plus an edge table, both held in external synchronous-read memories.
- For every outgoing edge it emits one synapse event (destination neuron, weight) to the synaptic accumulator over a valid/ready handshake.

Parameters:
- TAG_W, 8, width of a neuron tag (fire_fifo entry width).
- EPTR_W, 12, width of an edge-table address.
- W_W, 16, width of a synaptic weight (signed).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- asyn_reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; while high, the block may pop the FIFO.
- fifo_empty  in  1  fire_fifo empty flag.
- fifo_out_tag  in  TAG_W  head tag of fire_fifo, first-word-fall-through (valid whenever fifo_empty=0).
- fifo_deq  out  1  one-cycle pop strobe to fire_fifo.
- ptr_addr  out  TAG_W  pointer-table read address.
- ptr_rdata  in  2*EPTR_W  {end, begin}, valid 1 cycle after ptr_addr.
- edge_addr  out  EPTR_W  edge-table read address.
- edge_rdata  in  TAG_W+W_W  {dst, weight}, valid 1 cycle after edge_addr.
- syn_valid  out  1  synapse event valid.
- syn_ready  in  1  accumulator accepts the event.
- syn_dst  out  TAG_W  destination neuron.
- syn_weight  out  W_W  signed weight.
- busy  out  1  high whenever the state is not IDLE.
- ptr_err  out  1  sticky flag: a malformed pointer pair was seen.
- spike_cnt  out  CNT_W  number of tags popped since reset.
- event_cnt  out  CNT_W  number of synapse events accepted since reset.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. All outputs are 0: fifo_deq, syn_valid, busy, ptr_err, spike_cnt, event_cnt, and all address and data registers.
- IDLE:
  - If run=1 and fifo_empty=0: pulse fifo_deq for exactly one cycle, latch fifo_out_tag into cur_tag, drive ptr_addr=fifo_out_tag, spike_cnt++, go to PTR_WAIT.
  - Otherwise stay in IDLE with fifo_deq=0.
- PTR_WAIT: latch begin and end from ptr_rdata.
  - end==begin: go to IDLE (neuron has no edges).
  - end<begin: set ptr_err=1 and go to IDLE; the spike is counted but emits no events.
  - Otherwise set cur=begin, drive edge_addr=begin, go to EDGE_RD.
- EDGE_RD: edge_rdata becomes valid. Register it onto syn_dst and syn_weight, set syn_valid=1, go to EDGE_OUT.
- EDGE_OUT: syn_valid, syn_dst and syn_weight are held stable until syn_ready=1. On the handshake cycle:
  - event_cnt++, syn_valid drops the next cycle.
  - If cur+1==end, go to IDLE.
  - Otherwise cur++, edge_addr=cur+1, go to EDGE_RD.
- Throughput: 2 cycles per edge with syn_ready tied high. Latency from the pop to the first syn_valid is 3 cycles.
- Pop rules:
  - fifo_deq is never asserted outside IDLE.
  - fifo_deq is never asserted while fifo_empty=1.
  - At most one pop per spike.
- run deasserted mid-walk: the current neuron's edge list completes, then no further pops. run has no effect on a walk already in progress.
- Address arithmetic is unsigned and modulo 2^EPTR_W. An edge list ending at address 2^EPTR_W-1 is legal because end is exclusive and the compare is on cur+1.
- The counters wrap silently at 2^CNT_W.
- Reset asserted mid-walk: the walk is abandoned immediately. The in-flight event is lost and the popped tag is not re-queued.

Decomposition:
- Shared package fire_pkg:
  - TAG_W/EPTR_W/W_W defaults.
  - The state encoding (IDLE, PTR_WAIT, EDGE_RD, EDGE_OUT).
  - The ptr_rdata field offsets.
- One natural sub-module, fanout_counters: spike_cnt, event_cnt and the sticky ptr_err. Everything else stays in one FSM body.

Test Plan:
- Reset: hold asyn_reset_n=0 with the FIFO non-empty -> fifo_deq=0, syn_valid=0, busy=0, both counters 0.
- Single spike: FIFO holds tag 3, ptr[3]={end=7, begin=5}, syn_ready=1 -> exactly one fifo_deq, then events (edge[5]), (edge[6]) in order, then IDLE; spike_cnt=1, event_cnt=2.
- Backpressure: same as above with syn_ready low for 4 cycles on the first event -> syn_dst and syn_weight stable throughout, no duplicate event, event_cnt=2 at end.
- Zero and bad lists: tags 1 and 2 with ptr[1]={4,4} and ptr[2]={2,9} -> no syn_valid, spike_cnt=2, ptr_err=1 and stays 1.
- run drop: run falls while the 2nd of 3 edges is pending and the FIFO holds 2 more tags -> all 3 edges emitted, no further fifo_deq, busy=0.
- Wrap: ptr = {end=0, begin=4094} with EPTR_W=12 -> events from addresses 4094 and 4095 only.
